// File: rtl/deserializer_framer.sv
// rtl/deserializer_framer.sv - serial-to-byte deserializer with sync-word frame alignment
module deserializer_framer #(
   parameter logic [7:0]  SYNC_WORD = 8'hBC,
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned MISS_MAX  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic       sync_err
);

   localparam int BW = $clog2(FRAME_LEN + 1);
   localparam int MW = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;
   localparam logic [BW-1:0] SYNC_SLOT  = BW'(FRAME_LEN);
   localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_MAX - 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state_q;
   logic [6:0]      sr_q;          // seven most recent bits; the eighth is data_in
   logic [7:0]      sr_d;          // next shift value, doubles as the byte window
   logic [2:0]      bit_cnt_q;
   logic [BW-1:0]   byte_cnt_q;
   logic [MW-1:0]   miss_cnt_q;
   logic [7:0]      data_out_q;
   logic            data_valid_q;
   logic            locked_q;
   logic            sync_err_q;

   logic            sync_hit;
   logic            byte_done;
   logic            in_sync_slot;

   // Byte window: the byte whose MSB is arriving on data_in this cycle
   always_comb begin
      sr_d         = {data_in, sr_q};
      sync_hit     = (sr_d == SYNC_WORD);
      byte_done    = (bit_cnt_q == 3'd7);
      in_sync_slot = (byte_cnt_q == SYNC_SLOT);
   end

   // Alignment FSM with registered outputs and frame counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         miss_cnt_q   <= '0;
         data_out_q   <= 8'h00;
         data_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         sr_q         <= sr_d[7:1];
         data_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
         case (state_q)
            HUNT: begin
               if (sync_hit) begin
                  state_q    <= VERIFY;
                  bit_cnt_q  <= '0;
                  byte_cnt_q <= '0;
               end
            end
            VERIFY: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (byte_done) begin
                  if (!in_sync_slot) begin
                     // payload during verification is discarded
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end else begin
                     byte_cnt_q <= '0;
                     if (sync_hit) begin
                        state_q    <= LOCKED;
                        miss_cnt_q <= '0;
                        locked_q   <= 1'b1;
                     end else begin
                        state_q <= HUNT;
                     end
                  end
               end
            end
            LOCKED: begin
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (byte_done) begin
                  if (!in_sync_slot) begin
                     // a payload byte equal to SYNC_WORD is plain data here
                     data_out_q   <= sr_d;
                     data_valid_q <= 1'b1;
                     byte_cnt_q   <= byte_cnt_q + 1'b1;
                  end else begin
                     byte_cnt_q <= '0;
                     if (sync_hit) begin
                        miss_cnt_q <= '0;
                     end else begin
                        sync_err_q <= 1'b1;
                        if (miss_cnt_q == MISS_LIMIT) begin
                           state_q    <= HUNT;
                           miss_cnt_q <= '0;
                           locked_q   <= 1'b0;
                        end else begin
                           // alignment is trusted until the miss budget runs out
                           miss_cnt_q <= miss_cnt_q + 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign locked     = locked_q;
   assign sync_err   = sync_err_q;

endmodule
